// File: rtl/lfm_sweep_ctrl.sv
// Linear-FM sweep controller: streams phase increments that ramp from
// START_INC in NUM_STEPS beats, with an idle gap between chirps.
module lfm_sweep_ctrl #(
  parameter int unsigned         PHASE_W     = 32,
  parameter logic [PHASE_W-1:0]  START_INC   = PHASE_W'(32'h0010_0000),
  parameter logic [PHASE_W-1:0]  STEP_INC    = PHASE_W'(32'h0000_1000),
  parameter int unsigned         NUM_STEPS   = 256,
  parameter int unsigned         IDLE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               cfg_tvalid,
  input  logic               cfg_tready,
  output logic [PHASE_W-1:0] cfg_tdata,
  output logic               cfg_tlast,
  output logic               sweep_busy,
  output logic [15:0]        chirp_count
);

  localparam int BEAT_W = $clog2(NUM_STEPS + 1);
  localparam int GAP_W  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_STEPS - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  inc_q, inc_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [15:0]         chirp_q, chirp_d;
  logic                busy_q;
  logic                last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    chirp_d = chirp_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          inc_d   = START_INC;
          beat_d  = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (cfg_tready) begin
          inc_d  = inc_q + STEP_INC;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            chirp_d = chirp_q + 16'd1;
            if (IDLE_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end else if (enable) begin
              inc_d  = START_INC;
              beat_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_END) begin
          if (enable) begin
            inc_d   = START_INC;
            beat_d  = '0;
            state_d = SWEEP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      inc_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      chirp_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      chirp_q <= chirp_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Valid comes from state alone, so it never depends on tready.
  assign cfg_tvalid  = (state_q == SWEEP);
  assign cfg_tdata   = cfg_tvalid ? inc_q : '0;
  assign cfg_tlast   = cfg_tvalid && last_beat;
  assign sweep_busy  = busy_q;
  assign chirp_count = chirp_q;

endmodule

// File: doc/lfm_sweep_ctrl.md
# lfm_sweep_ctrl

Linear-FM sweep controller that generates the phase-increment stream consumed by the DDS configuration channel. It produces one increment word per accepted beat, stepping linearly from a start value through a fixed number of steps, with a programmable idle gap between chirps. It sits upstream of `dds_stream` as the master of its configuration interface, so that the DDS sine output becomes a repeating chirp.

## Interface
- PHASE_W, 32, width of the phase-increment word.
- START_INC, 32'h0010_0000, increment of the first beat of every chirp.
- STEP_INC, 32'h0000_1000, amount added to the increment after each accepted beat.
- NUM_STEPS, 256, beats per chirp; must be at least 1.
- IDLE_CYCLES, 16, cycles with `cfg_tvalid` low between chirps; 0 is legal.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; starts chirps and keeps them repeating.
- cfg_tvalid  out  1  increment word valid.
- cfg_tready  in  1  DDS config channel ready.
- cfg_tdata  out  PHASE_W  phase increment.
- cfg_tlast  out  1  high on the final beat of a chirp.
- sweep_busy  out  1  high in SWEEP or GAP.
- chirp_count  out  16  number of completed chirps, modulo 2^16.

## Operation
- States:
  - IDLE: `cfg_tvalid`=0 and `sweep_busy`=0. If `enable`=1, load inc=START_INC and beat=0, then go to SWEEP.
  - SWEEP: `cfg_tvalid`=1, `cfg_tdata`=inc, `cfg_tlast`=(beat==NUM_STEPS-1).
    - On a handshake (`cfg_tvalid`&`cfg_tready`): inc<=inc+STEP_INC and beat<=beat+1.
    - On the tlast handshake: `chirp_count`+1, then go to GAP if IDLE_CYCLES>0. Otherwise reload START_INC and stay in SWEEP if `enable`=1, or go to IDLE if `enable`=0.
  - GAP: count IDLE_CYCLES cycles. At the end, reload START_INC and go to SWEEP if `enable`=1, else go to IDLE.
- Arithmetic:
  - inc addition is modulo 2^PHASE_W; wrap-around is silent.
  - The beat counter is $clog2(NUM_STEPS+1) bits wide.
  - `chirp_count` wraps from 65535 to 0.
- AXI-stream rules:
  - Once `cfg_tvalid` is asserted it stays high, with `cfg_tdata`/`cfg_tlast` stable, until the handshake.
  - `cfg_tvalid` never depends combinationally on `cfg_tready`.
- Enable deasserted mid-chirp: the current chirp completes, including its tlast beat and any gap, then the block enters IDLE. A chirp is never truncated.
- Enable reasserted during GAP: the next chirp follows normally.
- NUM_STEPS=1: every beat is a tlast beat carrying START_INC.
- Reset in any state, including a stalled beat: next cycle is IDLE, all outputs 0, `chirp_count`=0, and the pending beat is discarded.

## Timing
- Reset values: `cfg_tvalid`=0, `cfg_tdata`=0, `cfg_tlast`=0, `sweep_busy`=0, `chirp_count`=0.
- `enable` sampled high in IDLE at edge N: `cfg_tvalid`=1 with START_INC after edge N.
- Throughput: with `cfg_tready` held high, one beat per cycle. A chirp occupies exactly NUM_STEPS cycles.
- Handshake at edge N: the next word is presented after edge N, with zero bubble.
- Gap: the last handshake at edge N gives `cfg_tvalid` low for exactly IDLE_CYCLES cycles, then high again after edge N+IDLE_CYCLES.
- `chirp_count` updates at the same edge as the tlast handshake.
- `sweep_busy` is registered: high from the edge that enters SWEEP until the edge that enters IDLE.

## Test plan
- Defaults, `cfg_tready`=1, enable pulsed once:
  - expect 256 consecutive beats 0x00100000, 0x00101000, …, 0x001FF000;
  - `cfg_tlast` only on beat 255;
  - then 16 cycles with `cfg_tvalid` low;
  - then IDLE with `chirp_count`=1.
- Random `cfg_tready` backpressure (~40% low): tdata/tlast stable while stalled, sequence identical to the first scenario, no beat dropped or duplicated.
- `enable` held high, IDLE_CYCLES=0: tlast beat 0x001FF000 is followed immediately by 0x00100000; `chirp_count` steps 1, 2, 3 on consecutive tlast beats.
- START_INC=32'hFFFF_F000, STEP_INC=32'h1000, NUM_STEPS=4: beats FFFFF000, 00000000, 00001000, 00002000 (wrap).
- Reset asserted on beat 100 while `cfg_tready`=0: next cycle `cfg_tvalid`=0 and `chirp_count`=0. On re-enable the sweep restarts at START_INC.
- `enable` dropped at beat 10: the chirp runs through beat 255 and the gap, then IDLE with `sweep_busy`=0. NUM_STEPS=1 case: every beat is 0x00100000 with tlast=1.
